morse_key_sequencer: RTL and testbench

Front-end controller for the Morse decoder. It turns a single raw telegraph key into the timed symbol stream that the decoder consumes: DOT, DASH, CHAR_END and WORD_END events. It synchronises and debounces the key, classifies each press by duration and detects inter-character and inter-word gaps. Events go out over a valid/ready handshake with 2-entry buffering, so the decoder or HPS bridge can stall without losing events.

---
 rtl/morse_pkg.sv | 36 +++
 rtl/morse_debounce.sv | 62 ++++++
 rtl/morse_key_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg
// Shared types for the Morse front end and the decoder behind it:
//   evt_t     - event codes carried on evt_type (DOT, DASH, CHAR_END, WORD_END)
//   SYM_*     - single-bit DOT/DASH symbol encoding used by the decoder
//   state_t   - key sequencer FSM states
//   evt_rec_t - one buffered event (type + error flag)
package morse_pkg;

  typedef enum logic [1:0] {
    EVT_DOT      = 2'd0,
    EVT_DASH     = 2'd1,
    EVT_CHAR_END = 2'd2,
    EVT_WORD_END = 2'd3
  } evt_t;

  // Symbol encoding the decoder shifts into its character register.
  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    evt_t typ;
    logic err;
  } evt_rec_t;

  function automatic evt_t sym_to_evt(input logic sym);
    return (sym == SYM_DASH) ? EVT_DASH : EVT_DOT;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// morse_debounce
// Two-flop synchroniser plus tick-based debounce for the raw telegraph key.
// The debounced level only follows the synchronised key after it has
// differed from the current debounced level for DEB_TICKS consecutive ticks.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   key_in  in  raw key, asynchronous, active-high
//   tick    in  1-cycle timing tick from the prescaler
//   key_db  out debounced key level
module morse_debounce #(
  parameter int DEB_TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  input  logic tick,
  output logic key_db
);

  localparam int CW = (DEB_TICKS < 2) ? 1 : $clog2(DEB_TICKS + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          key_db_q, key_db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    key_db_d = key_db_q;
    if (sync2_q == key_db_q) begin
      // Any agreeing cycle restarts the stability window.
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEB_TICKS - 1)) begin
        key_db_d = ~key_db_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      key_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      key_db_q <= key_db_d;
      cnt_q    <= cnt_d;
    end
  end

  assign key_db = key_db_q;

endmodule

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer
// Turns a raw telegraph key into DOT / DASH / CHAR_END / WORD_END events.
// Presses are classified by length in ticks, release gaps mark character
// and word boundaries. Events leave through a 2-entry FIFO on a valid/ready
// handshake; a push into a full FIFO is dropped and flags overrun.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   key_in       in  raw key, asynchronous, active-high
//   evt_valid    out head event available
//   evt_type     out head event code (morse_pkg::evt_t)
//   evt_err      out with CHAR_END: character had more than MAX_SYMS symbols
//   evt_ready    in  consumer accepts head event when high with evt_valid
//   overrun      out sticky: an event was dropped on a full buffer
//   clr_overrun  in  clears overrun (a same-cycle drop wins)
//   key_db       out debounced key level
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEB_TICKS      = 10,
  parameter int DOT_MAX_TICKS  = 200,
  parameter int CHAR_GAP_TICKS = 400,
  parameter int WORD_GAP_TICKS = 1000,
  parameter int MAX_SYMS       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       evt_valid,
  output logic [1:0] evt_type,
  output logic       evt_err,
  input  logic       evt_ready,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       key_db
);

  // dur only has to tell "<= DOT_MAX" from "longer", so it stops one past it.
  localparam int DUR_SAT = DOT_MAX_TICKS + 1;
  localparam int PW      = $clog2(TICK_DIV);
  localparam int DW      = $clog2(DUR_SAT + 1);
  localparam int GW      = $clog2(WORD_GAP_TICKS + 1);
  localparam int SW      = $clog2(MAX_SYMS + 1);

  // ---------------- prescaler ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // ---------------- debounce ----------------
  logic key_db_w;

  morse_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .tick   (tick),
    .key_db (key_db_w)
  );

  assign key_db = key_db_w;

  logic key_prev_q, key_prev_d;
  logic key_rise, key_fall;

  assign key_prev_d = key_db_w;
  assign key_rise   = key_db_w & ~key_prev_q;
  assign key_fall   = ~key_db_w & key_prev_q;

  // ---------------- FSM and duration counters ----------------
  state_t        state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic          bad_q, bad_d;
  logic          push;
  evt_rec_t      push_rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dur_d        = dur_q;
    gap_d        = gap_q;
    sym_cnt_d    = sym_cnt_q;
    bad_d        = bad_q;
    push         = 1'b0;
    push_rec.typ = EVT_DOT;
    push_rec.err = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_rise) begin
          dur_d   = '0;
          state_d = PRESS;
        end
      end

      PRESS: begin
        if (tick && dur_q != DW'(DUR_SAT)) begin
          dur_d = dur_q + DW'(1);
        end
        if (key_fall) begin
          if (sym_cnt_q < SW'(MAX_SYMS)) begin
            push         = 1'b1;
            push_rec.typ = sym_to_evt((dur_q <= DW'(DOT_MAX_TICKS)) ? SYM_DOT : SYM_DASH);
            sym_cnt_d    = sym_cnt_q + SW'(1);
          end else begin
            // Overlong character: swallow the symbol, report it on CHAR_END.
            bad_d = 1'b1;
          end
          gap_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (tick && gap_q != GW'(WORD_GAP_TICKS)) begin
          gap_d = gap_q + GW'(1);
        end
        if (gap_q == GW'(CHAR_GAP_TICKS)) begin
          push         = 1'b1;
          push_rec.typ = EVT_CHAR_END;
          push_rec.err = bad_q;
          sym_cnt_d    = '0;
          bad_d        = 1'b0;
          state_d      = WORD_WAIT;
        end
        // A new press overrides the target state but not the event above.
        if (key_rise) begin
          dur_d   = '0;
          state_d = PRESS;
        end
      end

      WORD_WAIT: begin
        if (tick && gap_q != GW'(WORD_GAP_TICKS)) begin
          gap_d = gap_q + GW'(1);
        end
        if (gap_q == GW'(WORD_GAP_TICKS)) begin
          push         = 1'b1;
          push_rec.typ = EVT_WORD_END;
          state_d      = IDLE;
        end
        if (key_rise) begin
          dur_d   = '0;
          state_d = PRESS;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------- 2-entry output FIFO ----------------
  // Slot 0 is always the head; a pop shifts slot 1 down.
  evt_rec_t   slot_q [2];
  evt_rec_t   slot_d [2];
  logic [1:0] buf_cnt_q, buf_cnt_d;
  logic [1:0] buf_cnt_mid;
  logic       overrun_q, overrun_d;
  logic       pop;
  logic       drop;

  assign pop = (buf_cnt_q != 2'd0) && evt_ready;

  always_comb begin
    slot_d      = slot_q;
    buf_cnt_mid = buf_cnt_q - {1'b0, pop};
    buf_cnt_d   = buf_cnt_mid;
    overrun_d   = overrun_q;
    drop        = 1'b0;

    if (pop) begin
      slot_d[0] = slot_q[1];
    end
    if (push) begin
      if (buf_cnt_mid != 2'd2) begin
        slot_d[buf_cnt_mid[0]] = push_rec;
        buf_cnt_d              = buf_cnt_mid + 2'd1;
      end else begin
        drop = 1'b1;
      end
    end

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      key_prev_q <= 1'b0;
      dur_q      <= '0;
      gap_q      <= '0;
      sym_cnt_q  <= '0;
      bad_q      <= 1'b0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      buf_cnt_q  <= 2'd0;
      overrun_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      key_prev_q <= key_prev_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      sym_cnt_q  <= sym_cnt_d;
      bad_q      <= bad_d;
      slot_q     <= slot_d;
      buf_cnt_q  <= buf_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  assign evt_valid = (buf_cnt_q != 2'd0);
  assign evt_type  = slot_q[0].typ;
  assign evt_err   = slot_q[0].err;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed testbench for morse_key_sequencer with small timing parameters.
// Key presses are a multiple of TICK_DIV cycles long, so the debounced
// pulse is exactly as long as the raw one and dur = press_cycles / TICK_DIV.
module tb_morse_key_sequencer;

  localparam int TD = 4;

  localparam logic [1:0] T_DOT  = 2'd0;
  localparam logic [1:0] T_DASH = 2'd1;
  localparam logic [1:0] T_CEND = 2'd2;
  localparam logic [1:0] T_WEND = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic       evt_err;
  logic       evt_ready;
  logic       overrun;
  logic       clr_overrun;
  logic       key_db;

  always #5 clk = ~clk;

  morse_key_sequencer #(
    .TICK_DIV       (TD),
    .DEB_TICKS      (2),
    .DOT_MAX_TICKS  (3),
    .CHAR_GAP_TICKS (5),
    .WORD_GAP_TICKS (12),
    .MAX_SYMS       (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .evt_valid   (evt_valid),
    .evt_type    (evt_type),
    .evt_err     (evt_err),
    .evt_ready   (evt_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .key_db      (key_db)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Accepted events, captured between clock edges.
  logic [1:0] got_t [$];
  logic       got_e [$];

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      got_t.push_back(evt_type);
      got_e.push_back(evt_err);
    end
  end

  int         exp_n;
  logic [1:0] exp_t [8];
  logic       exp_e [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_add(input logic [1:0] t, input logic e);
    exp_t[exp_n] = t;
    exp_e[exp_n] = e;
    exp_n++;
  endtask

  task automatic press(input int hold, input int rel);
    key_in = 1'b1;
    cycles(hold);
    key_in = 1'b0;
    cycles(rel);
  endtask

  task automatic check_events(input string name);
    check($sformatf("%s count", name), got_t.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_t.size(); i++) begin
      check($sformatf("%s evt%0d type", name, i), got_t[i], exp_t[i]);
      if (exp_t[i] == T_CEND)
        check($sformatf("%s evt%0d err", name, i), got_e[i], exp_e[i]);
    end
    got_t.delete();
    got_e.delete();
    exp_n = 0;
  endtask

  typedef struct {
    int         press_cycles;
    logic [1:0] exp_sym;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{8,  T_DOT};   // 2 ticks
    vecs[1] = '{12, T_DOT};   // 3 ticks: longest DOT
    vecs[2] = '{16, T_DASH};  // 4 ticks: shortest DASH
    vecs[3] = '{32, T_DASH};  // 8 ticks

    exp_n       = 0;
    rst_n       = 1'b0;
    key_in      = 1'b0;
    evt_ready   = 1'b1;
    clr_overrun = 1'b0;
    cycles(3);
    check("reset evt_valid", evt_valid, 0);
    check("reset evt_type", evt_type, T_DOT);
    check("reset evt_err", evt_err, 0);
    check("reset overrun", overrun, 0);
    check("reset key_db", key_db, 0);
    rst_n = 1'b1;
    cycles(5);

    // Single presses: symbol, CHAR_END, WORD_END, then idle.
    for (int v = 0; v < 4; v++) begin
      press(vecs[v].press_cycles, 100);
      exp_add(vecs[v].exp_sym, 1'b0);
      exp_add(T_CEND, 1'b0);
      exp_add(T_WEND, 1'b0);
      check_events($sformatf("single%0d", v));
      check($sformatf("single%0d idle valid", v), evt_valid, 0);
    end

    // N: DASH then DOT in one character.
    press(32, 8);
    press(8, 100);
    exp_add(T_DASH, 1'b0);
    exp_add(T_DOT, 1'b0);
    exp_add(T_CEND, 1'b0);
    exp_add(T_WEND, 1'b0);
    check_events("letter_n");

    // Glitch in the release gap must not move key_db or add a symbol.
    begin
      int hi_cnt;
      hi_cnt = 0;
      press(8, 20);
      key_in = 1'b1;
      cycles(1);
      key_in = 1'b0;
      for (int i = 0; i < 40; i++) begin
        cycles(1);
        if (key_db) hi_cnt++;
      end
      check("glitch key_db high cycles", hi_cnt, 0);
      cycles(60);
      exp_add(T_DOT, 1'b0);
      exp_add(T_CEND, 1'b0);
      exp_add(T_WEND, 1'b0);
      check_events("glitch");
    end

    // Six presses: fifth symbol is the last, CHAR_END carries err.
    for (int p = 0; p < 6; p++) press(8, 8);
    cycles(100);
    for (int p = 0; p < 5; p++) exp_add(T_DOT, 1'b0);
    exp_add(T_CEND, 1'b1);
    exp_add(T_WEND, 1'b0);
    check_events("six_sym");

    // Stalled consumer: two events held, WORD_END dropped.
    evt_ready = 1'b0;
    press(8, 100);
    check("stall overrun set", overrun, 1);
    check("stall evt_valid", evt_valid, 1);
    check("stall head type", evt_type, T_DOT);
    cycles(3);
    check("stall head stable", evt_type, T_DOT);
    evt_ready = 1'b1;
    cycles(5);
    exp_add(T_DOT, 1'b0);
    exp_add(T_CEND, 1'b0);
    check_events("stall");
    check("stall drained", evt_valid, 0);
    check("overrun sticky", overrun, 1);
    clr_overrun = 1'b1;
    cycles(1);
    clr_overrun = 1'b0;
    check("overrun cleared", overrun, 0);

    // Reset mid-press with the key still held.
    begin
      int budget;
      budget = 0;
      key_in = 1'b1;
      while (!key_db && budget < 50) begin
        cycles(1);
        budget++;
      end
      check("pre-reset key_db rose", key_db, 1);
      cycles(4);
      rst_n = 1'b0;
      cycles(2);
      check("mid reset key_db", key_db, 0);
      check("mid reset evt_valid", evt_valid, 0);
      rst_n = 1'b1;
      cycles(20);       // synchronised key high for 20 cycles = 5 ticks
      key_in = 1'b0;
      cycles(100);
      exp_add(T_DASH, 1'b0);
      exp_add(T_CEND, 1'b0);
      exp_add(T_WEND, 1'b0);
      check_events("reset_press");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
